muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS execute stage. It sits beside the ALU, takes the same rs/rt operands, and computes MULT/MULTU/DIV/DIVU over multiple cycles into the architectural HI/LO registers. Those registers feed the writeback result mux (MFHI/MFLO). The controller stalls the pipeline while `busy` is high.

---
 rtl/muldiv_unit.sv | 94 +++++++++
 tb/tb_muldiv_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle MULT/MULTU/DIV/DIVU into HI/LO registers.
// Optional macro MULDIV_DIV0_FAST_EN: divide by zero skips the iteration phase.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2;
  logic [1:0] state;
  logic [4:0] cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] dvs, a_cap;
  logic [1:0] op_r;
  logic sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag, diff, q, r, res_hi, res_lo;
  logic [WIDTH:0] sum, t;
  logic [2*WIDTH-1:0] prod, step;
  logic ge, neg;
  always_comb begin
    a_mag = (op[0] && a[WIDTH-1]) ? -a : a;
    b_mag = (op[0] && b[WIDTH-1]) ? -b : b;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? dvs : '0};
    t = acc[2*WIDTH-1:WIDTH-1];
    ge = t >= {1'b0, dvs};
    diff = t[WIDTH-1:0] - dvs;
    step = op_r[1] ? {ge ? diff : t[WIDTH-1:0], acc[WIDTH-2:0], ge} : {sum, acc[WIDTH-1:1]};
    neg = op_r[0] & (sa ^ sb);
    prod = neg ? -acc : acc;
    q = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r = (op_r[0] & sa) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    // Divide by zero bypasses the sign fix-up and reports the raw dividend.
    res_hi = !op_r[1] ? prod[2*WIDTH-1:WIDTH] : (dvs == '0) ? a_cap : r;
    res_lo = !op_r[1] ? prod[WIDTH-1:0] : (dvs == '0) ? '1 : q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            a_cap <= a;
            sa    <= op[0] & a[WIDTH-1];
            sb    <= op[0] & b[WIDTH-1];
            acc   <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
            dvs   <= op[1] ? b_mag : a_mag;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef MULDIV_DIV0_FAST_EN
            state <= (op[1] && b == '0) ? FINISH : RUN;
`else
            state <= RUN;
`endif
          end else begin
            if (we_hi) hi <= wd;
            if (we_lo) lo <= wd;
          end
        end
        RUN: begin
          acc <= step;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FINISH;
        end
        FINISH: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a queue scoreboard checked on done.
module tb_muldiv_unit;
  logic clk = 0, rst = 1, start = 0, we_hi = 0, we_lo = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0, wd = 0;
  logic busy, done;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct packed {logic [31:0] h; logic [31:0] l; int c;} exp_t;
  exp_t sb_q[$];
  logic prev_done = 0;
`ifdef MULDIV_DIV0_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 33;
`endif

  muldiv_unit dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wd(wd), .busy(busy), .done(done), .hi(hi), .lo(lo));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      checks++;
      if (prev_done) begin errors++; $display("FAIL done_width: done high two cycles, required one"); end
      if (sb_q.size() == 0) begin
        errors++; $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
      end else begin
        e = sb_q.pop_front();
        checks += 3;
        if (hi !== e.h) begin errors++; $display("FAIL hi: got %h required %h", hi, e.h); end
        if (lo !== e.l) begin errors++; $display("FAIL lo: got %h required %h", lo, e.l); end
        if (cyc != e.c) begin errors++; $display("FAIL latency: done at cycle %0d required %0d", cyc, e.c); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b required 0", busy); end
      end
    end
    prev_done <= done;
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input int lat, input bit inter);
    int s;
    bit seen = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1;
    @(posedge clk);
    #1 s = cyc;
    sb_q.push_back('{eh, el, s + lat});
    @(negedge clk);
    start = 0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b required 1", busy); end
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (inter && i == 5) begin start = 1; op = 2'b10; a = 32'd9; b = 32'd2; we_lo = 1; wd = 32'hDEAD; end
        if (inter && i == 6) begin start = 0; we_lo = 0; end
        if (i > 0) checks++;
        if (i > 0 && lat > 1 && busy !== 1'b1) begin errors++; $display("FAIL busy_run: got %b required 1", busy); end
        @(negedge clk);
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL timeout: done never seen for op %0d", o); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checks += 4;
    if (hi !== 0)   begin errors++; $display("FAIL reset_hi: got %h required 0", hi); end
    if (lo !== 0)   begin errors++; $display("FAIL reset_lo: got %h required 0", lo); end
    if (busy !== 0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (done !== 0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    rst = 0;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0);
    run_op(2'b01, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 33, 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0);
    run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 0);
    run_op(2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV0_LAT, 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, DIV0_LAT, 0);
    run_op(2'b01, 32'd1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FB2E, 33, 0);
    run_op(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 33, 1);
    @(negedge clk);
    we_hi = 1; wd = 32'hCAFE_0001;
    @(negedge clk);
    we_hi = 0;
    checks++;
    if (hi !== 32'hCAFE_0001) begin errors++; $display("FAIL mthi: got %h required cafe0001", hi); end
    op = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks += 4;
    if (hi !== 0)   begin errors++; $display("FAIL abort_hi: got %h required 0", hi); end
    if (lo !== 0)   begin errors++; $display("FAIL abort_lo: got %h required 0", lo); end
    if (busy !== 0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
    if (done !== 0) begin errors++; $display("FAIL abort_done: got %b required 0", done); end
    repeat (40) @(negedge clk);
    we_lo = 1; wd = 32'h1234;
    @(negedge clk);
    we_lo = 0;
    checks += 2;
    if (lo !== 32'h1234) begin errors++; $display("FAIL mtlo: got %h required 00001234", lo); end
    if (hi !== 0)        begin errors++; $display("FAIL mtlo_hi: got %h required 0", hi); end
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d entries required 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
